// File: rtl/ise.sv
// Image sorting engine: classifies streamed RGB images by dominant colour and
// mean intensity, then emits all images sorted by {colour, intensity, index}.
module ise #(
  parameter int IMAGE_NUM  = 32,
  parameter int IMAGE_SIZE = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  image_in_index,
  input  logic [23:0] pixel_in,
  output logic        busy,
  output logic        out_valid,
  output logic [1:0]  color_index,
  output logic [4:0]  image_out_index
);

  localparam logic [2:0] S_INPUT  = 3'd0;
  localparam logic [2:0] S_DIV    = 3'd1;
  localparam logic [2:0] S_SORT   = 3'd2;
  localparam logic [2:0] S_OUTPUT = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam int PIX = IMAGE_SIZE * IMAGE_SIZE;

  logic [2:0]  state_r;
  logic        busy_r, out_valid_r;
  logic [1:0]  color_index_r;
  logic [4:0]  image_out_index_r;
  logic [14:0] pix_cnt_r;
  logic [14:0] cnt_red_r, cnt_grn_r, cnt_blu_r;
  logic [21:0] sum_red_r, sum_grn_r, sum_blu_r;
  logic [4:0]  cur_idx_r;
  logic [5:0]  img_cnt_r, sort_cnt_r, out_cnt_r;
  logic [3:0]  step_r;
  logic [21:0] rem_r;
  logic [7:0]  quo_r;
  logic [1:0]  dom_r;
  // entry = {colour[14:13], intensity[12:5], index[4:0]}; ascending entry = sort order
  logic [14:0] table_r [IMAGE_NUM];
  logic [14:0] sorted_s [IMAGE_NUM];

  logic [7:0]  red_s, grn_s, blu_s;
  logic [1:0]  cls_s, dom_s;
  logic [21:0] sum_sel_s;
  logic [14:0] cnt_sel_s;
  logic [3:0]  shift_s;
  logic [22:0] trial_s;
  logic        ge_s;

  assign red_s = pixel_in[23:16];
  assign grn_s = pixel_in[15:8];
  assign blu_s = pixel_in[7:0];

  always_comb begin
    if (red_s >= grn_s && red_s >= blu_s) begin
      cls_s = 2'd0;
    end else if (grn_s >= blu_s) begin
      cls_s = 2'd1;
    end else begin
      cls_s = 2'd2;
    end
    if (cnt_red_r >= cnt_grn_r && cnt_red_r >= cnt_blu_r) begin
      dom_s     = 2'd0;
      sum_sel_s = sum_red_r;
    end else if (cnt_grn_r >= cnt_blu_r) begin
      dom_s     = 2'd1;
      sum_sel_s = sum_grn_r;
    end else begin
      dom_s     = 2'd2;
      sum_sel_s = sum_blu_r;
    end
  end

  // Restoring divider: quotient fits 8 bits since every sample is at most 255
  always_comb begin
    case (dom_r)
      2'd0:    cnt_sel_s = cnt_red_r;
      2'd1:    cnt_sel_s = cnt_grn_r;
      default: cnt_sel_s = cnt_blu_r;
    endcase
    shift_s = 4'd8 - step_r;
    trial_s = {8'd0, cnt_sel_s} << shift_s;
    ge_s    = ({1'b0, rem_r} >= trial_s);
  end

  // One odd-even transposition pass; IMAGE_NUM passes fully sort the table
  always_comb begin
    for (int i = 0; i < IMAGE_NUM; i++) begin
      int ip;
      int im;
      ip = (i < IMAGE_NUM - 1) ? i + 1 : i;
      im = (i > 0) ? i - 1 : i;
      if ((i % 2) == int'(sort_cnt_r[0]) && table_r[i] > table_r[ip]) begin
        sorted_s[i] = table_r[ip];
      end else if ((im % 2) == int'(sort_cnt_r[0]) && table_r[im] > table_r[i]) begin
        sorted_s[i] = table_r[im];
      end else begin
        sorted_s[i] = table_r[i];
      end
    end
  end

  // Main control: accumulate, divide, sort, emit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r           <= S_INPUT;
      busy_r            <= 1'b0;
      out_valid_r       <= 1'b0;
      color_index_r     <= 2'd0;
      image_out_index_r <= 5'd0;
      pix_cnt_r         <= 15'd0;
      cnt_red_r         <= 15'd0;
      cnt_grn_r         <= 15'd0;
      cnt_blu_r         <= 15'd0;
      sum_red_r         <= 22'd0;
      sum_grn_r         <= 22'd0;
      sum_blu_r         <= 22'd0;
      cur_idx_r         <= 5'd0;
      img_cnt_r         <= 6'd0;
      sort_cnt_r        <= 6'd0;
      out_cnt_r         <= 6'd0;
      step_r            <= 4'd0;
      rem_r             <= 22'd0;
      quo_r             <= 8'd0;
      dom_r             <= 2'd0;
      for (int i = 0; i < IMAGE_NUM; i++) table_r[i] <= 15'd0;
    end else begin
      case (state_r)
        S_INPUT: begin
          if (!busy_r) begin
            if (pix_cnt_r == 15'd0) cur_idx_r <= image_in_index;
            case (cls_s)
              2'd0: begin
                cnt_red_r <= cnt_red_r + 15'd1;
                sum_red_r <= sum_red_r + {14'd0, red_s};
              end
              2'd1: begin
                cnt_grn_r <= cnt_grn_r + 15'd1;
                sum_grn_r <= sum_grn_r + {14'd0, grn_s};
              end
              default: begin
                cnt_blu_r <= cnt_blu_r + 15'd1;
                sum_blu_r <= sum_blu_r + {14'd0, blu_s};
              end
            endcase
            if (pix_cnt_r == 15'(PIX - 1)) begin
              pix_cnt_r <= 15'd0;
              busy_r    <= 1'b1;
              step_r    <= 4'd0;
              state_r   <= S_DIV;
            end else begin
              pix_cnt_r <= pix_cnt_r + 15'd1;
            end
          end
        end
        S_DIV: begin
          if (step_r == 4'd0) begin
            dom_r  <= dom_s;
            rem_r  <= sum_sel_s;
            quo_r  <= 8'd0;
            step_r <= 4'd1;
          end else begin
            if (ge_s) rem_r <= rem_r - trial_s[21:0];
            quo_r <= {quo_r[6:0], ge_s};
            if (step_r == 4'd8) begin
              table_r[img_cnt_r[4:0]] <= {dom_r, quo_r[6:0], ge_s, cur_idx_r};
              cnt_red_r <= 15'd0;
              cnt_grn_r <= 15'd0;
              cnt_blu_r <= 15'd0;
              sum_red_r <= 22'd0;
              sum_grn_r <= 22'd0;
              sum_blu_r <= 22'd0;
              img_cnt_r <= img_cnt_r + 6'd1;
              step_r    <= 4'd0;
              if (img_cnt_r == 6'(IMAGE_NUM - 1)) begin
                sort_cnt_r <= 6'd0;
                state_r    <= S_SORT;
              end else begin
                busy_r  <= 1'b0;
                state_r <= S_INPUT;
              end
            end else begin
              step_r <= step_r + 4'd1;
            end
          end
        end
        S_SORT: begin
          for (int i = 0; i < IMAGE_NUM; i++) table_r[i] <= sorted_s[i];
          sort_cnt_r <= sort_cnt_r + 6'd1;
          if (sort_cnt_r == 6'(IMAGE_NUM - 1)) begin
            out_cnt_r <= 6'd0;
            state_r   <= S_OUTPUT;
          end
        end
        S_OUTPUT: begin
          if (out_cnt_r == 6'(IMAGE_NUM)) begin
            out_valid_r <= 1'b0;
            state_r     <= S_DONE;
          end else begin
            out_valid_r       <= 1'b1;
            color_index_r     <= table_r[out_cnt_r[4:0]][14:13];
            image_out_index_r <= table_r[out_cnt_r[4:0]][4:0];
            out_cnt_r         <= out_cnt_r + 6'd1;
          end
        end
        S_DONE: begin
          out_valid_r <= 1'b0;
          busy_r      <= 1'b1;
        end
        default: begin
          state_r     <= S_DONE;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b1;
        end
      endcase
    end
  end

  assign busy            = busy_r;
  assign out_valid       = out_valid_r;
  assign color_index     = color_index_r;
  assign image_out_index = image_out_index_r;

endmodule

// File: tb/tb_ise.sv
// Directed bench for ise with small 4x4 images; each task checks its own scenario.
module tb_ise;
  localparam int SIZE = 4;
  localparam int PIX  = SIZE * SIZE;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  image_in_index;
  logic [23:0] pixel_in;
  logic        busy, out_valid;
  logic [1:0]  color_index;
  logic [4:0]  image_out_index;

  ise #(.IMAGE_NUM(32), .IMAGE_SIZE(SIZE)) dut (
    .clk(clk), .reset(reset), .image_in_index(image_in_index), .pixel_in(pixel_in),
    .busy(busy), .out_valid(out_valid), .color_index(color_index),
    .image_out_index(image_out_index)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, timeouts = 0;
  logic [23:0] pix_a [32];
  logic [23:0] pix_b [32];
  int          n_a [32];
  int          order_q [32];
  logic [1:0]  exp_col [32];
  logic [4:0]  exp_idx [32];
  logic [1:0]  got_col [32];
  logic [4:0]  got_idx [32];
  int          got_n, first_cyc, last_cyc;

  task automatic send_pixel(input logic [4:0] idx, input logic [23:0] pix);
    int guard = 0;
    while (busy !== 1'b0 && guard < 64) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 64) timeouts++;
    image_in_index = idx;
    pixel_in = pix;
    @(posedge clk); #1;
  endtask

  task automatic send_image(input int k);
    for (int p = 0; p < PIX; p++)
      send_pixel(5'(k), (p < n_a[k]) ? pix_a[k] : pix_b[k]);
  endtask

  task automatic run_images();
    for (int k = 0; k < 32; k++) send_image(order_q[k]);
    pixel_in = 'x;
    image_in_index = 'x;
  endtask

  task automatic collect();
    got_n = 0; first_cyc = -1; last_cyc = -1;
    for (int c = 0; c < 400; c++) begin
      if (out_valid === 1'b1) begin
        if (got_n < 32) begin
          got_col[got_n] = color_index;
          got_idx[got_n] = image_out_index;
        end
        if (first_cyc < 0) first_cyc = c;
        last_cyc = c;
        got_n++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic set_uniform(input int k, input logic [23:0] pix);
    pix_a[k] = pix; pix_b[k] = pix; n_a[k] = PIX;
  endtask

  task automatic test_reset();
    reset = 1'b1; pixel_in = 24'd0; image_in_index = 5'd0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
    checks++; if (color_index !== 2'd0) begin errors++; $display("FAIL reset_color got %0d want 0", color_index); end
    checks++; if (image_out_index !== 5'd0) begin errors++; $display("FAIL reset_index got %0d want 0", image_out_index); end
  endtask

  task automatic test_reset_midstream();
    for (int k = 0; k < 32; k++) begin
      set_uniform(k, {8'(k + 1), 16'd0});
      order_q[k] = 31 - k;
    end
    reset = 1'b0;
    for (int p = 0; p < 40; p++) send_pixel(5'(31 - p / PIX), pix_a[31 - p / PIX]);
    reset = 1'b1;
    #2;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midstream_busy got %b want 0", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midstream_valid got %b want 0", out_valid); end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_all_red();
    timeouts = 0;
    run_images();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL red_busy_after_input got %b want 1", busy); end
    collect();
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (got_col[i] !== 2'd0 || got_idx[i] !== 5'(i)) begin
        errors++;
        $display("FAIL red_entry%0d got (%0d,%0d) want (0,%0d)", i, got_col[i], got_idx[i], i);
      end
    end
    checks++; if (got_n !== 32) begin errors++; $display("FAIL red_count got %0d want 32", got_n); end
    checks++; if (last_cyc - first_cyc !== 31) begin errors++; $display("FAIL red_contiguous got %0d want 31", last_cyc - first_cyc); end
    checks++; if (timeouts !== 0) begin errors++; $display("FAIL red_timeouts got %0d want 0", timeouts); end
  endtask

  task automatic test_mixed();
    set_uniform(0, 24'h0000C8);
    set_uniform(1, 24'h003200);
    set_uniform(2, 24'h0A0000);
    for (int k = 3; k < 32; k++) set_uniform(k, 24'h404040);
    for (int k = 0; k < 32; k++) order_q[k] = k;
    exp_col[0] = 2'd0; exp_idx[0] = 5'd2;
    for (int k = 3; k < 32; k++) begin exp_col[k - 2] = 2'd0; exp_idx[k - 2] = 5'(k); end
    exp_col[30] = 2'd1; exp_idx[30] = 5'd1;
    exp_col[31] = 2'd2; exp_idx[31] = 5'd0;
    timeouts = 0;
    pulse_reset();
    run_images();
    collect();
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (got_col[i] !== exp_col[i] || got_idx[i] !== exp_idx[i]) begin
        errors++;
        $display("FAIL mixed_entry%0d got (%0d,%0d) want (%0d,%0d)", i, got_col[i], got_idx[i], exp_col[i], exp_idx[i]);
      end
    end
    checks++; if (got_n !== 32) begin errors++; $display("FAIL mixed_count got %0d want 32", got_n); end
    checks++; if (timeouts !== 0) begin errors++; $display("FAIL mixed_timeouts got %0d want 0", timeouts); end
  endtask

  task automatic test_ties();
    int exp_order [11];
    set_uniform(0, 24'h808000);
    set_uniform(1, 24'h008080);
    pix_a[2] = 24'h0A0000; pix_b[2] = 24'h00FA00; n_a[2] = PIX / 2;
    set_uniform(3, 24'h7F0000);
    set_uniform(4, 24'h810000);
    set_uniform(5, 24'h00C800);
    set_uniform(6, 24'h090000);
    set_uniform(7, 24'h0B0000);
    pix_a[8] = 24'h650000; pix_b[8] = 24'h640000; n_a[8] = PIX / 2;
    set_uniform(9, 24'h640000);
    pix_a[10] = 24'h3C0000; pix_b[10] = 24'h0000FF; n_a[10] = PIX - 4;
    for (int k = 11; k < 32; k++) set_uniform(k, 24'h000005);
    for (int k = 0; k < 32; k++) order_q[k] = (k + 5) % 32;
    exp_order = '{6, 2, 7, 10, 8, 9, 3, 0, 4, 1, 5};
    for (int i = 0; i < 11; i++) begin
      exp_idx[i] = 5'(exp_order[i]);
      exp_col[i] = (i < 9) ? 2'd0 : 2'd1;
    end
    for (int k = 11; k < 32; k++) begin exp_col[k] = 2'd2; exp_idx[k] = 5'(k); end
    timeouts = 0;
    pulse_reset();
    run_images();
    collect();
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (got_col[i] !== exp_col[i] || got_idx[i] !== exp_idx[i]) begin
        errors++;
        $display("FAIL ties_entry%0d got (%0d,%0d) want (%0d,%0d)", i, got_col[i], got_idx[i], exp_col[i], exp_idx[i]);
      end
    end
    checks++; if (got_n !== 32) begin errors++; $display("FAIL ties_count got %0d want 32", got_n); end
    checks++; if (timeouts !== 0) begin errors++; $display("FAIL ties_timeouts got %0d want 0", timeouts); end
  endtask

  task automatic test_done_hold();
    repeat (20) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b1 || color_index !== 2'd2 || image_out_index !== 5'd31) begin
        errors++;
        $display("FAIL done_hold got v=%b b=%b c=%0d i=%0d want v=0 b=1 c=2 i=31",
                 out_valid, busy, color_index, image_out_index);
      end
    end
  endtask

  task automatic test_reset_midoutput();
    int guard = 0;
    for (int k = 0; k < 32; k++) begin
      set_uniform(k, {8'(k + 1), 16'd0});
      order_q[k] = k;
    end
    pulse_reset();
    run_images();
    while (out_valid !== 1'b1 && guard < 400) begin
      @(posedge clk); #1;
      guard++;
    end
    checks++; if (guard >= 400) begin errors++; $display("FAIL midoutput_wait got timeout want out_valid"); end
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b1;
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midoutput_valid got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midoutput_busy got %b want 0", busy); end
    checks++;
    if (color_index !== 2'd0 || image_out_index !== 5'd0) begin
      errors++;
      $display("FAIL midoutput_outs got (%0d,%0d) want (0,0)", color_index, image_out_index);
    end
  endtask

  initial begin
    test_reset();
    test_reset_midstream();
    test_all_red();
    test_mixed();
    test_ties();
    test_done_hold();
    test_reset_midoutput();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
